// File: rtl/cbx_param_cfg.sv
// Connection box with a serial configuration chain: pass-through routing tracks, per-pin
// track muxes selected from the chain, and a load-tracking FSM gating the grid pins.
module cbx_param_cfg #(
  parameter int unsigned CHAN_WIDTH = 20,
  parameter int unsigned NUM_IPIN   = 9,
  parameter int unsigned MUX_SIZE   = 10
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [NUM_IPIN-1:0]   bottom_grid_pin,
  output logic                  ccff_tail,
  output logic                  cfg_done
);

  localparam int unsigned SEL_BITS = $clog2(MUX_SIZE);
  localparam int unsigned CFG_BITS = NUM_IPIN * SEL_BITS;
  localparam int unsigned CntW     = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {StUncfg, StLoading, StDone} state_e;

  state_e              state_q;
  logic [CFG_BITS-1:0] cfg_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cnt_inc;
  logic                cfg_done_q;
  logic [NUM_IPIN-1:0] grid_pin;

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;
  assign ccff_tail       = cfg_q[CFG_BITS-1];
  assign cfg_done        = cfg_done_q;
  assign bottom_grid_pin = grid_pin;
  assign cnt_inc         = cnt_q + CntW'(1);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cfg_q      <= '0;
      cnt_q      <= '0;
      state_q    <= StUncfg;
      cfg_done_q <= 1'b0;
    end else if (ccff_en) begin
      cfg_q <= {cfg_q[CFG_BITS-2:0], ccff_head};
      unique case (state_q)
        StUncfg, StLoading: begin
          cnt_q <= cnt_inc;
          if (cnt_inc == CntW'(CFG_BITS)) begin
            state_q    <= StDone;
            cfg_done_q <= 1'b1;
          end else begin
            state_q    <= StLoading;
            cfg_done_q <= 1'b0;
          end
        end
        StDone: begin
          // Live reconfiguration: keep shifting, counter stays saturated.
          cnt_q      <= CntW'(CFG_BITS);
          cfg_done_q <= 1'b1;
        end
        default: begin
          cnt_q      <= '0;
          state_q    <= StUncfg;
          cfg_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin : mux_blk
    logic [SEL_BITS-1:0] sel;
    int unsigned         t;
    sel      = '0;
    t        = 0;
    grid_pin = '0;
    for (int unsigned i = 0; i < NUM_IPIN; i++) begin
      sel = cfg_q[i*SEL_BITS +: SEL_BITS];
      // Input pairs step two tracks apart; each pin is staggered by its own index.
      for (int unsigned j = 0; j < MUX_SIZE; j++) begin
        if (int'(sel) == int'(j)) begin
          t = (2 * (j / 2) + i) % CHAN_WIDTH;
          grid_pin[i] = (j % 2 == 0) ? chanx_left_in[t] : chanx_right_in[t];
        end
      end
    end
    if (!cfg_done_q) grid_pin = '0;
  end

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Directed bench for cbx_param_cfg at default parameters (20 tracks, 9 pins, 36 config bits).
module tb_cbx_param_cfg;

  logic        prog_clk;
  logic        prog_reset;
  logic        ccff_head;
  logic        ccff_en;
  logic [19:0] chanx_left_in;
  logic [19:0] chanx_right_in;
  logic [19:0] chanx_left_out;
  logic [19:0] chanx_right_out;
  logic [8:0]  bottom_grid_pin;
  logic        ccff_tail;
  logic        cfg_done;

  int n_pass;
  int n_chk;

  cbx_param_cfg dut (
    .prog_clk        (prog_clk),
    .prog_reset      (prog_reset),
    .ccff_head       (ccff_head),
    .ccff_en         (ccff_en),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .bottom_grid_pin (bottom_grid_pin),
    .ccff_tail       (ccff_tail),
    .cfg_done        (cfg_done)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic do_reset();
    prog_reset = 1'b1;
    ccff_en    = 1'b0;
    @(posedge prog_clk);
    #1;
    prog_reset = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    ccff_head = b;
    ccff_en   = 1'b1;
    @(posedge prog_clk);
    #1;
    ccff_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge prog_clk);
      #1;
    end
  endtask

  // Shifts v[first] down to v[last]; after all 36 bits, cfg equals v.
  task automatic load_bits(input logic [35:0] v, input int first, input int last);
    for (int k = first; k >= last; k--) shift_bit(v[k]);
  endtask

  task automatic test_reset();
    chanx_left_in  = '0;
    chanx_right_in = '0;
    do_reset();
    n_chk++; if (cfg_done !== 1'b0) $display("FAIL reset_done: got %b want 0", cfg_done);
    else n_pass++;
    n_chk++; if (ccff_tail !== 1'b0) $display("FAIL reset_tail: got %b want 0", ccff_tail);
    else n_pass++;
    n_chk++; if (bottom_grid_pin !== 9'h000)
      $display("FAIL reset_pins: got %h want 000", bottom_grid_pin);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    chanx_left_in  = 20'hAAAAA;
    chanx_right_in = 20'h55555;
    #1;
    n_chk++; if (chanx_right_out !== 20'hAAAAA)
      $display("FAIL pt_right: got %h want AAAAA", chanx_right_out);
    else n_pass++;
    n_chk++; if (chanx_left_out !== 20'h55555)
      $display("FAIL pt_left: got %h want 55555", chanx_left_out);
    else n_pass++;
    n_chk++; if (bottom_grid_pin !== 9'h000 || cfg_done !== 1'b0)
      $display("FAIL pt_unconfigured: got pins=%h done=%b want 000/0", bottom_grid_pin, cfg_done);
    else n_pass++;
    prog_reset     = 1'b1;
    chanx_left_in  = 20'h12345;
    chanx_right_in = 20'hFEDCB;
    #1;
    n_chk++; if (chanx_right_out !== 20'h12345 || chanx_left_out !== 20'hFEDCB)
      $display("FAIL pt_in_reset: got %h/%h want 12345/FEDCB", chanx_right_out, chanx_left_out);
    else n_pass++;
    @(posedge prog_clk);
    #1;
    prog_reset = 1'b0;
  endtask

  task automatic test_full_load();
    logic [35:0] v;
    v = {9{4'd3}};
    chanx_left_in  = '0;
    chanx_right_in = 20'h007FC;  // tracks 2..10: sel 3 taps right track i+2
    do_reset();
    load_bits(v, 35, 1);
    n_chk++; if (cfg_done !== 1'b0 || bottom_grid_pin !== 9'h000)
      $display("FAIL load35: got done=%b pins=%h want 0/000", cfg_done, bottom_grid_pin);
    else n_pass++;
    shift_bit(v[0]);
    n_chk++; if (cfg_done !== 1'b1) $display("FAIL load36_done: got %b want 1", cfg_done);
    else n_pass++;
    n_chk++; if (bottom_grid_pin !== 9'h1FF)
      $display("FAIL load36_pins: got %h want 1FF", bottom_grid_pin);
    else n_pass++;
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'h00000;
    #1;
    n_chk++; if (bottom_grid_pin !== 9'h000)
      $display("FAIL sel3_left_ignored: got %h want 000", bottom_grid_pin);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [35:0] v;
    v = 36'h9A5C396E1;
    do_reset();
    for (int k = 35; k >= 1; k--) begin
      shift_bit(v[k]);
      idle(5);
      if (k == 20) begin
        n_chk++; if (cfg_done !== 1'b0) $display("FAIL gap_mid_done: got %b want 0", cfg_done);
        else n_pass++;
      end
    end
    n_chk++; if (cfg_done !== 1'b0 || ccff_tail !== 1'b0)
      $display("FAIL gap35: got done=%b tail=%b want 0/0", cfg_done, ccff_tail);
    else n_pass++;
    shift_bit(v[0]);
    n_chk++; if (cfg_done !== 1'b1 || ccff_tail !== 1'b1)
      $display("FAIL gap36: got done=%b tail=%b want 1/1", cfg_done, ccff_tail);
    else n_pass++;
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'h00000;
    #1;
    n_chk++; if (bottom_grid_pin !== 9'h004)
      $display("FAIL gap_pins_left: got %h want 004", bottom_grid_pin);
    else n_pass++;
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'hFFFFF;
    #1;
    n_chk++; if (bottom_grid_pin !== 9'h159)
      $display("FAIL gap_pins_right: got %h want 159", bottom_grid_pin);
    else n_pass++;
  endtask

  task automatic test_sel_range();
    logic [35:0] v;
    v = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd12};
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'hFFFFF;
    do_reset();
    load_bits(v, 35, 0);
    n_chk++; if (bottom_grid_pin !== 9'h1FE)
      $display("FAIL sel_invalid: got %h want 1FE", bottom_grid_pin);
    else n_pass++;
    // All pins sel 8: left track i+8; only even pins see a set track.
    v = {9{4'd8}};
    chanx_left_in  = 20'h15500;
    chanx_right_in = 20'hFFFFF;
    do_reset();
    load_bits(v, 35, 0);
    n_chk++; if (bottom_grid_pin !== 9'h155)
      $display("FAIL sel8_tracks: got %h want 155", bottom_grid_pin);
    else n_pass++;
  endtask

  task automatic test_reset_priority();
    logic [35:0] ones;
    ones = '1;
    do_reset();
    load_bits(ones, 35, 17);  // 19 shifts
    prog_reset = 1'b1;
    shift_bit(1'b1);          // shift 20 collides with reset
    prog_reset = 1'b0;
    n_chk++; if (cfg_done !== 1'b0 || ccff_tail !== 1'b0)
      $display("FAIL rst_loading: got done=%b tail=%b want 0/0", cfg_done, ccff_tail);
    else n_pass++;
    load_bits(ones, 35, 1);
    n_chk++; if (cfg_done !== 1'b0)
      $display("FAIL rst_recount35: got %b want 0", cfg_done);
    else n_pass++;
    shift_bit(1'b1);
    n_chk++; if (cfg_done !== 1'b1 || ccff_tail !== 1'b1)
      $display("FAIL rst_recount36: got done=%b tail=%b want 1/1", cfg_done, ccff_tail);
    else n_pass++;
    prog_reset = 1'b1;
    shift_bit(1'b1);
    prog_reset = 1'b0;
    n_chk++; if (cfg_done !== 1'b0 || ccff_tail !== 1'b0 || bottom_grid_pin !== 9'h000)
      $display("FAIL rst_done: got done=%b tail=%b pins=%h want 0/0/000",
               cfg_done, ccff_tail, bottom_grid_pin);
    else n_pass++;
  endtask

  task automatic test_live_shift();
    logic [35:0] v;
    v = 36'h111101111;  // every sel 1 except sel_4 = 0
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'hFFFFF;
    do_reset();
    load_bits(v, 35, 0);
    n_chk++; if (bottom_grid_pin !== 9'h1EF)
      $display("FAIL live_before: got %h want 1EF", bottom_grid_pin);
    else n_pass++;
    shift_bit(1'b0);  // sels become 2, sel_4 stays 0
    n_chk++; if (cfg_done !== 1'b1 || bottom_grid_pin !== 9'h000)
      $display("FAIL live_shift0: got done=%b pins=%h want 1/000", cfg_done, bottom_grid_pin);
    else n_pass++;
    shift_bit(1'b1);  // sel_0 = 5, others 4, sel_4 = 0
    n_chk++; if (cfg_done !== 1'b1 || bottom_grid_pin !== 9'h001)
      $display("FAIL live_shift1: got done=%b pins=%h want 1/001", cfg_done, bottom_grid_pin);
    else n_pass++;
  endtask

  initial begin
    n_pass         = 0;
    n_chk          = 0;
    prog_reset     = 1'b0;
    ccff_en        = 1'b0;
    ccff_head      = 1'b0;
    chanx_left_in  = '0;
    chanx_right_in = '0;
    test_reset();
    test_passthrough();
    test_full_load();
    test_gaps();
    test_sel_range();
    test_reset_priority();
    test_live_shift();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
